// File: rtl/fir_out_buffer.sv
// Output buffer for the I/Q FIR: rounds and scales results, saturates them,
// and queues them in a first-word-fall-through FIFO with sticky flags.
// Ports: clk, Reset (async, high); PushIn/FI/FQ sample in (no backpressure);
// OutValid/OutReady/OI/OQ head out; Level, AlmostFull, Overflow, SatFlag
// status; ClearFlags clears the sticky flags.
module fir_out_buffer #(
  parameter int DEPTH = 8,
  parameter int SHIFT = 8,
  parameter int OUT_W = 24
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     PushIn,
  input  logic [31:0]              FI,
  input  logic [31:0]              FQ,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [OUT_W-1:0]         OI,
  output logic [OUT_W-1:0]         OQ,
  output logic [$clog2(DEPTH):0]   Level,
  output logic                     AlmostFull,
  output logic                     Overflow,
  output logic                     SatFlag,
  input  logic                     ClearFlags
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic signed [32:0] RND  = 33'sd1 <<< (SHIFT - 1);
  localparam logic signed [32:0] MAXV = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
  localparam logic signed [32:0] MINV = -(33'sd1 <<< (OUT_W - 1));

  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [LW-1:0] AF   = LW'(DEPTH - 2);

  // Returns {saturated, value}; the add before the shift rounds half up.
  function automatic logic [OUT_W:0] scale(input logic [31:0] x);
    logic signed [32:0] sum;
    logic signed [32:0] sh;
    logic               sat;
    logic [OUT_W-1:0]   val;
    sum = $signed({x[31], x}) + RND;
    sh  = sum >>> SHIFT;
    sat = 1'b0;
    val = sh[OUT_W-1:0];
    if (sh > MAXV) begin
      sat = 1'b1;
      val = MAXV[OUT_W-1:0];
    end else if (sh < MINV) begin
      sat = 1'b1;
      val = MINV[OUT_W-1:0];
    end
    return {sat, val};
  endfunction

  logic [OUT_W:0]   sc_i;
  logic [OUT_W:0]   sc_q;
  logic             s1_valid;
  logic [OUT_W-1:0] s1_i;
  logic [OUT_W-1:0] s1_q;

  logic [OUT_W-1:0] mem_i [DEPTH];
  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level;

  logic pop;
  logic full;
  logic wr_en;
  logic ovf_ev;
  logic sat_ev;

  always_comb begin
    sc_i = scale(FI);
    sc_q = scale(FQ);
  end

  assign full   = (level == FULL);
  assign pop    = OutValid && OutReady;
  // A full FIFO still takes the write when the head leaves on the same edge.
  assign wr_en  = s1_valid && (!full || pop);
  assign ovf_ev = s1_valid && full && !pop;
  assign sat_ev = PushIn && (sc_i[OUT_W] || sc_q[OUT_W]);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_i     <= '0;
      s1_q     <= '0;
    end else begin
      s1_valid <= PushIn;
      s1_i     <= sc_i[OUT_W-1:0];
      s1_q     <= sc_q[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_i[wr_ptr] <= s1_i;
      mem_q[wr_ptr] <= s1_q;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !pop)
        level <= level + LW'(1);
      else if (pop && !wr_en)
        level <= level - LW'(1);
    end
  end

  // Set events win over a simultaneous clear.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      Overflow <= 1'b0;
      SatFlag  <= 1'b0;
    end else begin
      Overflow <= (Overflow && !ClearFlags) || ovf_ev;
      SatFlag  <= (SatFlag && !ClearFlags) || sat_ev;
    end
  end

  assign Level      = level;
  assign OutValid   = (level != '0);
  assign AlmostFull = (level >= AF);
  // Storage is not reset, so mask the head while empty.
  assign OI = OutValid ? mem_i[rd_ptr] : '0;
  assign OQ = OutValid ? mem_q[rd_ptr] : '0;

endmodule

// File: doc/fir_out_buffer.md
FIR_OUT_BUFFER -- requirements
Module: fir_out_buffer

Interface
REQ-001 Parameter DEPTH, default 8, output FIFO entries; SHALL be a power of two, at least 4.
REQ-002 Parameter SHIFT, default 8, right-shift applied to filter outputs; SHALL be 1..16.
REQ-003 Parameter OUT_W, default 24, output sample width.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 PushIn  input  1  filter output valid for one cycle; no backpressure to the filter.
REQ-007 FI  input  32  signed I filter result.
REQ-008 FQ  input  32  signed Q filter result.
REQ-009 OutValid  output  1  head FIFO entry valid.
REQ-010 OutReady  input  1  consumer accepts the head entry.
REQ-011 OI  output  OUT_W  signed I of head entry.
REQ-012 OQ  output  OUT_W  signed Q of head entry.
REQ-013 Level  output  log2(DEPTH)+1  FIFO occupancy.
REQ-014 AlmostFull  output  1  Level >= DEPTH-2; feeds upstream pull throttling.
REQ-015 Overflow  output  1  sticky; a sample was dropped.
REQ-016 SatFlag  output  1  sticky; a sample saturated.
REQ-017 ClearFlags  input  1  synchronous clear of Overflow and SatFlag.

Function
REQ-018 Stage 1 SHALL register scaled I and Q plus a valid bit s1_valid on every edge; s1_valid = PushIn.
REQ-019 Scaling per component SHALL be: sign-extend to 33 bits, add 2^(SHIFT-1), arithmetic shift right by SHIFT (round half toward +inf).
REQ-020 Shifted value above 2^(OUT_W-1)-1 SHALL clamp to 2^(OUT_W-1)-1; below -2^(OUT_W-1) SHALL clamp to -2^(OUT_W-1).
REQ-021 Any clamp on I or Q of a pushed sample SHALL set SatFlag at the Stage-1 edge.
REQ-022 Stage 2 SHALL write the Stage-1 value into the FIFO on the edge after s1_valid is high.
REQ-023 FIFO SHALL be first-word-fall-through: OutValid = (Level != 0); OI and OQ show the head entry combinationally from registers.
REQ-024 A pop SHALL occur on an edge where OutValid and OutReady are both high.
REQ-025 OI and OQ SHALL hold stable while OutValid is high and OutReady is low.
REQ-026 Latency: PushIn sampled at edge k into an empty FIFO SHALL give OutValid high after edge k+1.
REQ-027 Write when Level == DEPTH with no pop on the same edge: drop the sample, leave Level unchanged, set Overflow.
REQ-028 Write and pop on the same edge when Level == DEPTH: accept the write, Level stays DEPTH, no Overflow.
REQ-029 Write and pop on the same edge at any Level: Level unchanged, order preserved.
REQ-030 Pop when Level == 0 SHALL be impossible: it is gated by OutValid.
REQ-031 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-032 ClearFlags SHALL clear both flags at the edge; a set event on the same edge wins, leaving the flag set.
REQ-033 Back-to-back PushIn every cycle SHALL be sustained without loss while Level < DEPTH.

Reset
REQ-034 Reset asserted SHALL immediately force OutValid=0, Level=0, AlmostFull=0, Overflow=0, SatFlag=0, OI=0, OQ=0; both pointers and s1_valid SHALL go to 0.
REQ-035 Reset mid-operation SHALL discard all FIFO contents and any Stage-1 sample.
REQ-036 Reset SHALL not clear FIFO storage RAM, but OI/OQ SHALL read 0 while Level==0.
REQ-037 First PushIn SHALL be honoured on the first rising edge after Reset deasserts.

Verification (SHIFT=8, OUT_W=24, DEPTH=8)
REQ-038 FI=384, FQ=-384 pushed into empty FIFO, OutReady=1 -> OutValid high after 2 edges, OI=2, OQ=-1, SatFlag=0.
REQ-039 FI=0x7FFFFFFF, FQ=0x80000000 -> OI=0x7FFFFF, OQ=0x800000, SatFlag=1 until ClearFlags.
REQ-040 OutReady=0, 10 consecutive pushes of values 1..10 (x256) -> Level=8, AlmostFull from Level 6, Overflow=1; then OutReady=1 -> outputs 1..8 in order, then OutValid=0.
REQ-041 Level=8 with push and pop on the same edge -> Level stays 8, Overflow stays 0, new sample appears last.
REQ-042 Reset asserted with Level=5 and a sample in Stage 1 -> OutValid=0, Level=0 immediately; no stale output after release.
REQ-043 ClearFlags and a saturating sample on the same edge -> SatFlag=1; ClearFlags alone on the next edge -> SatFlag=0.
